vector_element_sequencer: RTL and testbench
===========================================

// Module: vector_element_sequencer
// PURPOSE
//  Sits directly downstream of the vector control unit. Takes one decoded vector instruction
//  (vl, vstart) per handshake; walks its active element range in groups of NUM_LANES.
//  Per cycle it emits a base element offset plus a per-lane active mask to the vector
//  regfile/FU issue logic, and pulses done on the final group.
//  Honours pipeline stall and flush from the hazard unit.
// PARAMETERS
//  NUM_LANES  2  elements issued per cycle (power of 2, >=1)
//  VL_WIDTH   8  width of vl/vstart/offset (max vl = 2**VL_WIDTH-1)
// PORTS
//  CLK          in   1                 clock
//  RST          in   1                 synchronous reset, active-high
//  start        in   1                 new decoded instr valid (qualified by ready)
//  vl           in   VL_WIDTH          vector length of instr, sampled on accept
//  vstart       in   VL_WIDTH          first element index, sampled on accept
//  stall        in   1                 freeze sequencer, hold all outputs
//  flush        in   1                 abort current instr
//  ready        out  1                 sequencer idle, can accept start
//  busy         out  1                 instr in flight (RUN or EMPTY)
//  elem_valid   out  1                 offset/lane_active valid this cycle
//  offset       out  VL_WIDTH          element index of lane 0
//  lane_active  out  NUM_LANES         bit i = (offset+i < vl)
//  done         out  1                 final group (or empty instr) this cycle
// BEHAVIOUR
//  States: IDLE, RUN, EMPTY. Reset -> IDLE; offset=0, lane_active=0, elem_valid=0, done=0,
//   busy=0, ready=1; latched vl=0.
//  ready = (state==IDLE); busy = !ready. Accept = start & ready & !stall & !flush.
//  IDLE: on accept latch vl; if vl==0 or vstart>=vl -> EMPTY, else -> RUN, offset<=vstart.
//   start with !accept is dropped (not queued). Outputs elem_valid/done/lane_active = 0.
//  RUN: elem_valid=1; lane_active[i] = (offset+i < vl), compared at VL_WIDTH+1 bits.
//   last = (offset+NUM_LANES >= vl) at VL_WIDTH+1 bits (no wrap at vl=2**VL_WIDTH-1).
//   done = last. If !stall: last -> IDLE (offset<=0), else offset<=offset+NUM_LANES.
//   vstart need not be lane-aligned; first group begins exactly at vstart.
//  EMPTY: one cycle (unless stalled): done=1, elem_valid=0, lane_active=0; !stall -> IDLE.
//  Latency: first group visible the cycle after accept; N groups take N unstalled cycles;
//   ready re-asserts the cycle after done (no back-to-back accept on the done cycle).
//  stall=1: state, offset, all outputs held exactly; done stays high if on final group.
//  flush=1 (priority over stall and start): next state IDLE, offset<=0; done not pulsed for
//   the aborted instr; outputs in the flush cycle are still the current combinational values.
//  RST mid-RUN: next cycle reset values, any in-flight instr discarded.
//  Simultaneous stall+flush -> flush wins. start+flush in IDLE -> start dropped.
// TESTING
//  vl=5,vstart=0 (NUM_LANES=2) -> offsets 0,2,4 on 3 consecutive cycles; lane_active 11,11,01;
//   done only with offset 4; ready=1 the following cycle.
//  vl=8,vstart=3 -> offsets 3,5,7; lane_active 11,11,01; done on offset 7.
//  vl=0 (and separately vl=4,vstart=4) -> one EMPTY cycle: done=1, elem_valid=0, then ready=1.
//  vl=6, stall held 3 cycles while offset=2 -> offset 2/lane_active 11 stable 4 cycles,
//   then 4, done; total 6 cycles from first group.
//  vl=6, flush while offset=2 -> next cycle ready=1, elem_valid=0, done never seen;
//   start+flush in same IDLE cycle -> not accepted, stays IDLE.
//  vl=255,vstart=250 -> offsets 250,252,254; last lane_active 01, done=1, no wrap to 0;
//   RST asserted mid-run at offset 252 -> reset values next cycle.

Source files
------------

// File: rtl/vector_element_sequencer.sv
// Walks a vector instruction's active element range in groups of NUM_LANES,
// emitting a base offset and per-lane active mask each cycle.
module vector_element_sequencer #(
    parameter int NUM_LANES = 2,
    parameter int VL_WIDTH  = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic [VL_WIDTH-1:0] vl,
    input  logic [VL_WIDTH-1:0] vstart,
    input  logic                stall,
    input  logic                flush,
    output logic                ready,
    output logic                busy,
    output logic                elem_valid,
    output logic [VL_WIDTH-1:0] offset,
    output logic [NUM_LANES-1:0] lane_active,
    output logic                done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        EMPTY
    } state_t;

    localparam logic [VL_WIDTH:0]   LANES_X = (VL_WIDTH+1)'(NUM_LANES);
    localparam logic [VL_WIDTH-1:0] LANES_N = VL_WIDTH'(NUM_LANES);

    state_t              state_q;
    state_t              state_d;
    logic [VL_WIDTH-1:0] offset_q;
    logic [VL_WIDTH-1:0] offset_d;
    logic [VL_WIDTH-1:0] vl_q;
    logic [VL_WIDTH-1:0] vl_d;
    logic [VL_WIDTH:0]   offset_x;
    logic [VL_WIDTH:0]   vl_x;
    logic                last;
    logic                accept;

    // Widened by one bit so offset+NUM_LANES cannot wrap near max vl.
    assign offset_x = {1'b0, offset_q};
    assign vl_x     = {1'b0, vl_q};
    assign last     = (offset_x + LANES_X) >= vl_x;

    assign ready  = (state_q == IDLE);
    assign busy   = ~ready;
    assign offset = offset_q;
    assign accept = start & ready & ~stall & ~flush;

    always_comb begin
        lane_active = '0;
        if (state_q == RUN) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                lane_active[i] = (offset_x + (VL_WIDTH+1)'(i)) < vl_x;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        offset_d   = offset_q;
        vl_d       = vl_q;
        elem_valid = 1'b0;
        done       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    vl_d = vl;
                    if (vl == '0 || vstart >= vl) begin
                        state_d = EMPTY;
                    end else begin
                        state_d  = RUN;
                        offset_d = vstart;
                    end
                end
            end
            RUN: begin
                elem_valid = 1'b1;
                done       = last;
                if (!stall) begin
                    if (last) begin
                        state_d  = IDLE;
                        offset_d = '0;
                    end else begin
                        offset_d = offset_q + LANES_N;
                    end
                end
            end
            EMPTY: begin
                done = 1'b1;
                if (!stall) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d  = IDLE;
                offset_d = '0;
            end
        endcase
        // Flush aborts silently and outranks stall.
        if (flush) begin
            state_d  = IDLE;
            offset_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            offset_q <= '0;
            vl_q     <= '0;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            vl_q     <= vl_d;
        end
    end

endmodule

// File: tb/tb_vector_element_sequencer.sv
// Randomized and directed checks of vector_element_sequencer against a
// group-list reference model built from vl/vstart arithmetic.
module tb_vector_element_sequencer;

    localparam int L = 2;
    localparam int W = 8;

    logic         CLK;
    logic         RST;
    logic         start;
    logic [W-1:0] vl;
    logic [W-1:0] vstart;
    logic         stall;
    logic         flush;
    logic         ready;
    logic         busy;
    logic         elem_valid;
    logic [W-1:0] offset;
    logic [L-1:0] lane_active;
    logic         done;

    int vectors;
    int miscompares;

    typedef struct {
        int ev;
        int off;
        int mask;
        int dn;
    } grp_t;

    vector_element_sequencer #(
        .NUM_LANES(L),
        .VL_WIDTH (W)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .start      (start),
        .vl         (vl),
        .vstart     (vstart),
        .stall      (stall),
        .flush      (flush),
        .ready      (ready),
        .busy       (busy),
        .elem_valid (elem_valid),
        .offset     (offset),
        .lane_active(lane_active),
        .done       (done)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Expected group list: every L-element window from vstart below vl.
    function automatic void build_model(input int v, input int vs,
                                        output grp_t q[$]);
        grp_t g;
        q = {};
        if (vs >= v) begin
            g.ev = 0; g.off = 0; g.mask = 0; g.dn = 1;
            q.push_back(g);
        end else begin
            for (int o = vs; o < v; o += L) begin
                g.ev   = 1;
                g.off  = o;
                g.mask = 0;
                for (int i = 0; i < L; i++)
                    if (o + i < v) g.mask |= (1 << i);
                g.dn   = (o + L >= v) ? 1 : 0;
                q.push_back(g);
            end
        end
    endfunction

    // Issues one instruction and follows it to completion; stall_seq
    // forces stalls on chosen cycles, stall_pct adds random ones.
    task automatic run_instr(input int v, input int vs,
                             input logic [31:0] stall_seq,
                             input int stall_pct, output int cycles);
        grp_t q[$];
        int   idx;
        logic st;
        build_model(v, vs, q);
        vectors++;
        if (ready !== 1'b1) begin
            miscompares++;
            $display("FAIL issue_ready vl=%0d vs=%0d got=%b want=1",
                     v, vs, ready);
        end
        start  = 1'b1;
        vl     = W'(v);
        vstart = W'(vs);
        stall  = 1'b0;
        flush  = 1'b0;
        @(negedge CLK);
        start  = 1'b0;
        vl     = W'($urandom);
        vstart = W'($urandom);
        idx    = 0;
        cycles = 0;
        while (idx < q.size() && cycles < 2000) begin
            vectors++;
            if (elem_valid !== q[idx].ev[0] || offset !== W'(q[idx].off) ||
                lane_active !== L'(q[idx].mask) || done !== q[idx].dn[0] ||
                busy !== 1'b1) begin
                miscompares++;
                $display("FAIL group vl=%0d vs=%0d cyc=%0d got ev=%b off=%0d la=%b dn=%b bz=%b want ev=%0d off=%0d la=%0d dn=%0d bz=1",
                         v, vs, cycles, elem_valid, offset, lane_active,
                         done, busy, q[idx].ev, q[idx].off, q[idx].mask,
                         q[idx].dn);
            end
            st = (cycles < 32 && stall_seq[cycles]) ||
                 ($urandom_range(99) < stall_pct);
            stall = st;
            @(negedge CLK);
            if (!st) idx++;
            cycles++;
        end
        stall = 1'b0;
        vectors++;
        if (idx != q.size()) begin
            miscompares++;
            $display("FAIL timeout vl=%0d vs=%0d got=%0d want=%0d groups",
                     v, vs, idx, q.size());
        end
        vectors++;
        if (ready !== 1'b1 || done !== 1'b0 || elem_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL after_done vl=%0d vs=%0d got rdy=%b dn=%b ev=%b want 1 0 0",
                     v, vs, ready, done, elem_valid);
        end
    endtask

    task automatic do_reset();
        RST    = 1'b1;
        start  = 1'b0;
        vl     = '0;
        vstart = '0;
        stall  = 1'b0;
        flush  = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if (ready !== 1'b1 || busy !== 1'b0 || elem_valid !== 1'b0 ||
            offset !== '0 || lane_active !== '0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL reset got rdy=%b bz=%b ev=%b off=%0d la=%b dn=%b want 1 0 0 0 0 0",
                     ready, busy, elem_valid, offset, lane_active, done);
        end
    endtask

    task automatic test_directed();
        int c;
        run_instr(5, 0, 32'h0, 0, c);
        run_instr(8, 3, 32'h0, 0, c);
        run_instr(0, 0, 32'h0, 0, c);
        run_instr(4, 4, 32'h0, 0, c);
        run_instr(255, 250, 32'h0, 0, c);
        run_instr(1, 0, 32'h0, 0, c);
        run_instr(255, 0, 32'h0, 0, c);
    endtask

    task automatic test_stall();
        int c;
        run_instr(6, 0, 32'b1110, 0, c);
        vectors++;
        if (c != 6) begin
            miscompares++;
            $display("FAIL stall_cycles got=%0d want=6", c);
        end
        run_instr(3, 0, 32'b0, 0, c);
        run_instr(0, 0, 32'b11, 0, c);
    endtask

    task automatic test_flush();
        int seen_done;
        start  = 1'b1;
        vl     = 8'd6;
        vstart = 8'd0;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        vectors++;
        if (offset !== 8'd2 || elem_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_pre got off=%0d ev=%b want 2 1",
                     offset, elem_valid);
        end
        flush = 1'b1;
        stall = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        stall = 1'b0;
        vectors++;
        if (ready !== 1'b1 || elem_valid !== 1'b0 || offset !== '0) begin
            miscompares++;
            $display("FAIL flush_post got rdy=%b ev=%b off=%0d want 1 0 0",
                     ready, elem_valid, offset);
        end
        seen_done = 0;
        repeat (4) begin
            if (done === 1'b1) seen_done++;
            @(negedge CLK);
        end
        vectors++;
        if (seen_done != 0) begin
            miscompares++;
            $display("FAIL flush_no_done got=%0d want=0", seen_done);
        end
        start  = 1'b1;
        flush  = 1'b1;
        vl     = 8'd4;
        @(negedge CLK);
        start = 1'b0;
        flush = 1'b0;
        vectors++;
        if (ready !== 1'b1 || busy !== 1'b0 || elem_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL start_flush got rdy=%b bz=%b ev=%b want 1 0 0",
                     ready, busy, elem_valid);
        end
    endtask

    task automatic test_back_to_back();
        start  = 1'b1;
        vl     = 8'd3;
        vstart = 8'd0;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        vectors++;
        if (offset !== 8'd2 || done !== 1'b1 || lane_active !== 2'b01) begin
            miscompares++;
            $display("FAIL b2b_last got off=%0d dn=%b la=%b want 2 1 01",
                     offset, done, lane_active);
        end
        start  = 1'b1;
        vl     = 8'd4;
        vstart = 8'd0;
        @(negedge CLK);
        vectors++;
        if (ready !== 1'b1 || elem_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drop got rdy=%b ev=%b want 1 0",
                     ready, elem_valid);
        end
        @(negedge CLK);
        start = 1'b0;
        vectors++;
        if (elem_valid !== 1'b1 || offset !== '0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_accept got ev=%b off=%0d dn=%b want 1 0 0",
                     elem_valid, offset, done);
        end
        @(negedge CLK);
        vectors++;
        if (offset !== 8'd2 || done !== 1'b1 || lane_active !== 2'b11) begin
            miscompares++;
            $display("FAIL b2b_end got off=%0d dn=%b la=%b want 2 1 11",
                     offset, done, lane_active);
        end
        @(negedge CLK);
    endtask

    task automatic test_reset_midrun();
        start  = 1'b1;
        vl     = 8'd255;
        vstart = 8'd250;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        vectors++;
        if (offset !== 8'd252 || lane_active !== 2'b11) begin
            miscompares++;
            $display("FAIL midrun_pre got off=%0d la=%b want 252 11",
                     offset, lane_active);
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        vectors++;
        if (ready !== 1'b1 || busy !== 1'b0 || elem_valid !== 1'b0 ||
            offset !== '0 || lane_active !== '0 || done !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_rst got rdy=%b bz=%b ev=%b off=%0d la=%b dn=%b want 1 0 0 0 0 0",
                     ready, busy, elem_valid, offset, lane_active, done);
        end
    endtask

    task automatic test_random();
        int c;
        int v;
        int vs;
        for (int n = 0; n < 40; n++) begin
            v  = ($urandom_range(3) == 0) ? $urandom_range(255)
                                         : $urandom_range(12);
            vs = ($urandom_range(4) == 0) ? v + $urandom_range(2)
                                         : $urandom_range(v);
            if (vs > 255) vs = 255;
            run_instr(v, vs, 32'h0, 25, c);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_directed();
        test_stall();
        test_flush();
        test_back_to_back();
        test_reset_midrun();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
